// File: rtl/struct_s.sv
// Shared widths and FSM encoding for the 512-to-128 rule stream width converter.
package struct_s;

  localparam int RULE_W512       = 512;
  localparam int RULE_W128       = 128;
  localparam int RULE_LANES      = 4;
  localparam int RULE_EMPTY512_W = 6;
  localparam int RULE_EMPTY128_W = 4;
  localparam int RULE_LANE_W     = $clog2(RULE_LANES);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } unpack_state_e;

  // An eop beat with E unused bytes ends on lane 3 - floor(E/16); other beats use all lanes.
  function automatic logic [RULE_LANE_W-1:0] last_lane_of(
    input logic                       eop,
    input logic [RULE_EMPTY512_W-1:0] empty
  );
    last_lane_of = eop ? RULE_LANE_W'(RULE_LANES - 1) - empty[RULE_EMPTY512_W-1:RULE_EMPTY128_W]
                       : RULE_LANE_W'(RULE_LANES - 1);
  endfunction

endpackage

// File: rtl/rule_unpacker_512_128.sv
// Splits 512-bit rule beats into 128-bit flits, lowest lane first, from a single
// holding register; a new beat may load in the cycle its last flit is consumed.
module rule_unpacker_512_128
  import struct_s::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_rule_sop,
  input  logic                       in_rule_eop,
  input  logic [RULE_EMPTY512_W-1:0] in_rule_empty,
  input  logic                       in_rule_valid,
  input  logic [RULE_W512-1:0]       in_rule_data,
  output logic                       in_rule_ready,
  output logic                       out_rule_sop,
  output logic                       out_rule_eop,
  output logic [RULE_EMPTY128_W-1:0] out_rule_empty,
  output logic                       out_rule_valid,
  output logic [RULE_W128-1:0]       out_rule_data,
  input  logic                       out_rule_ready
);

  unpack_state_e              state_q, state_d;
  logic [RULE_W512-1:0]       hold_data;
  logic                       hold_sop, hold_eop;
  logic [RULE_LANE_W-1:0]     lane, last_lane;
  logic [RULE_EMPTY128_W-1:0] last_empty;
  logic                       full, lane_is_last, out_fire, in_accept;

  assign full         = (state_q == ST_DRAIN);
  assign lane_is_last = (lane == last_lane);
  assign out_fire     = full & out_rule_ready;
  assign in_accept    = in_rule_valid & in_rule_ready;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_accept) state_d = ST_DRAIN;
      ST_DRAIN: if (out_fire && lane_is_last && !in_accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // NOTE: the 512-bit hold register is reset too, so outputs read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_sop   <= 1'b0;
      hold_eop   <= 1'b0;
      last_lane  <= '0;
      last_empty <= '0;
      lane       <= '0;
    end else if (in_accept) begin
      // Reload wins over lane advance when the last flit and a new beat meet.
      hold_data  <= in_rule_data;
      hold_sop   <= in_rule_sop;
      hold_eop   <= in_rule_eop;
      last_lane  <= last_lane_of(in_rule_eop, in_rule_empty);
      last_empty <= in_rule_eop ? in_rule_empty[RULE_EMPTY128_W-1:0] : '0;
      lane       <= '0;
    end else if (out_fire && !lane_is_last) begin
      lane <= lane + 1'b1;
    end
  end

  always_comb begin
    in_rule_ready  = !full | (out_rule_ready & lane_is_last);
    out_rule_valid = full;
    out_rule_sop   = hold_sop & (lane == '0);
    out_rule_eop   = hold_eop & lane_is_last;
    out_rule_empty = out_rule_eop ? last_empty : '0;
    case (lane)
      2'd0:    out_rule_data = hold_data[0*RULE_W128 +: RULE_W128];
      2'd1:    out_rule_data = hold_data[1*RULE_W128 +: RULE_W128];
      2'd2:    out_rule_data = hold_data[2*RULE_W128 +: RULE_W128];
      default: out_rule_data = hold_data[3*RULE_W128 +: RULE_W128];
    endcase
  end

endmodule

// File: doc/rule_unpacker_512_128.md
# rule_unpacker_512_128

Width converter that splits 512-bit rule/packet beats from the PCIe side into 128-bit flits for the rule-matching datapath, the inverse of the 128→512 rule packer. Each accepted beat is held in one register and emitted lane by lane, lowest lane first. The `empty` byte count on the final beat sets how many flits are emitted and the `empty` on the last flit. It sits between the PCIe DMA rule stream and 128-bit consumers.

## Interface
- Parameters: none. Widths are fixed at 512 in and 128 out, taken from package constants.
- Clock and reset:
  - `clk`  in  1  single clock for all logic.
  - `rst_n`  in  1  asynchronous, active-low reset.
- Input stream:
  - `in_rule_sop`  in  1  first beat of a packet.
  - `in_rule_eop`  in  1  last beat of a packet.
  - `in_rule_empty`  in  6  unused bytes at the top of an eop beat, 0..63; ignored on non-eop beats.
  - `in_rule_valid`  in  1  beat valid.
  - `in_rule_data`  in  512  beat data; lane k = bits [128k+127:128k].
  - `in_rule_ready`  out  1  beat accepted when valid&ready.
- Output stream:
  - `out_rule_sop`  out  1  first flit of a packet.
  - `out_rule_eop`  out  1  last flit of a packet.
  - `out_rule_empty`  out  4  unused top bytes of the eop flit; 0 otherwise.
  - `out_rule_valid`  out  1  flit valid.
  - `out_rule_data`  out  128  flit data.
  - `out_rule_ready`  in  1  flit consumed when valid&ready.

## Operation
- Holding register: `hold_data[511:0]`, `hold_sop`, `hold_eop`, `last_lane[1:0]`, `last_empty[3:0]`, `lane[1:0]`, `full`.
- On acceptance, the beat's fields are latched:
  - Non-eop beat: `last_lane = 3`, `last_empty = 0`.
  - Eop beat with empty E: `last_lane = 3 - E[5:4]`, `last_empty = E[3:0]`. Flits emitted = 4 - floor(E/16).
  - In all cases `lane = 0`, `full = 1`.
- The flit is driven from registers through the lane mux:
  - `out_rule_data = hold_data[lane]`, `out_rule_valid = full`.
  - `out_rule_sop = hold_sop & (lane == 0)`.
  - `out_rule_eop = hold_eop & (lane == last_lane)`.
  - `out_rule_empty = out_rule_eop ? last_empty : 0`.
- On out valid&ready:
  - If `lane != last_lane`, `lane` increments.
  - Otherwise `full` clears, unless a new beat is accepted in the same cycle.
- `in_rule_ready = !full | (out_rule_ready & lane == last_lane)`. This gives back-to-back beats with no bubble.
- Two states: EMPTY (`full` = 0) and DRAIN (`full` = 1).
  - EMPTY→DRAIN on input accept.
  - DRAIN→EMPTY when the last flit is consumed with no input accepted.
  - DRAIN→DRAIN with a reload when the last flit is consumed and an input beat is accepted in the same cycle.
- A beat with both sop and eop is a single-beat packet. The flit carries sop and eop together when `last_lane` = 0.
- Non-eop beats always emit 4 flits with `empty` = 0, whatever `in_rule_empty` carries.

## Timing
- Reset (async assert, deasserting sync to `clk`) clears `full`, `lane`, `hold_*`, `last_*`. All outputs read 0, except `in_rule_ready`, which is 1.
- Latency: a beat accepted at edge t gives its first flit valid after edge t, in the same cycle (registered output, 1-cycle latency).
- Throughput: 1 flit per cycle while `out_rule_ready` = 1. An input beat is accepted at most every N cycles, where N = flits per beat.
- Stall (`out_rule_ready` = 0): data, valid, sop, eop and empty hold stable; `valid` never drops without a handshake.
- Simultaneous last-flit consume and new beat: the reload takes priority and `lane` returns to 0.
- Reset mid-drain drops the held beat; no partial flits appear afterwards.

## Structure
- The shared package `struct_s` holds:
  - `RULE_W512` = 512 and `RULE_W128` = 128.
  - `RULE_LANES` = 4.
  - `RULE_EMPTY512_W` = 6 and `RULE_EMPTY128_W` = 4.
- Single module with no sub-modules; the lane mux is an inline case on `lane`.

## Test plan
- Single 4-flit packet: one beat, sop=eop=1, E=0, data lanes A/B/C/D → 4 flits A,B,C,D; sop on A, eop on D, empty=0 throughout.
- Short last beat: a 2-beat packet with E=37 on the last beat → 4 flits, then 2 flits. The final flit has eop=1 and empty=5; `in_rule_ready` is low for 3 and then 1 cycles.
- Minimum: sop=eop=1 beat with E=63 → exactly 1 flit, sop=eop=1, empty=15.
- Back-to-back: 8 non-eop beats with a constant `out_rule_ready`=1 → 32 contiguous flits with no bubble; `in_rule_ready` pulses on each last lane.
- Backpressure: a random `out_rule_ready` duty of 30% → flit order and values match a scoreboard, and outputs stay stable while stalled.
- Reset mid-drain: assert `rst_n`=0 at lane 2 → `out_rule_valid`=0 immediately. After release, a new packet starts cleanly with sop at lane 0.
